rom_byte_unpacker: RTL

Reader for the 64-bit `file_rom` word stream. It pulls words from the ROM with `cs` under credit control and buffers them in a 2-entry FIFO. It serialises each word into bytes on a valid/ready stream for the LZW encoder input, and flags the final byte of the file. It sits between `file_rom` and the compressor core, and throttles the ROM whenever the byte consumer stalls.

---
 rtl/rom_byte_unpacker.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/rom_byte_unpacker.sv
// Pulls 64-bit words from file_rom under credit control into a 2-entry FIFO and
// serialises them MSB-first onto a byte valid/ready stream, flagging the final byte.
module rom_byte_unpacker #(
    parameter int WORD_W     = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        last_word_bytes,
    output logic              cs,
    input  logic              valid,
    input  logic [WORD_W-1:0] data_out,
    input  logic              eof,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              byte_last,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] DEPTH_C = 3'(FIFO_DEPTH);

    state_t              state_r;
    state_t              state_s;
    logic [WORD_W-1:0]   mem_r [0:1];
    logic                eof_mem_r [0:1];
    logic                wr_ptr_r;
    logic                rd_ptr_r;
    logic [1:0]          count_r;
    logic [2:0]          idx_r;
    logic                cs_q_r;
    logic                eof_seen_r;

    logic                cs_s;
    logic                credit_s;
    logic                wr_en_s;
    logic                hs_s;
    logic                pop_s;
    logic [2:0]          last_idx_s;
    logic [WORD_W-1:0]   head_word_s;
    logic                head_eof_s;
    logic                byte_valid_s;
    logic                byte_last_s;
    logic [7:0]          byte_sel_s;

    // Effective index of the final byte in the eof word (0 or >8 means a full word)
    always_comb begin
        if ((last_word_bytes == 4'd0) || (last_word_bytes > 4'd8)) begin
            last_idx_s = 3'd7;
        end else begin
            last_idx_s = 3'(last_word_bytes - 4'd1);
        end
    end

    // FIFO head view, handshake and pop decisions
    always_comb begin
        head_word_s  = mem_r[rd_ptr_r];
        head_eof_s   = eof_mem_r[rd_ptr_r];
        byte_valid_s = (count_r != 2'd0);
        hs_s         = byte_valid_s && byte_ready;
        byte_last_s  = byte_valid_s && head_eof_s && (idx_r == last_idx_s);
        pop_s        = hs_s && ((idx_r == 3'd7) || (head_eof_s && (idx_r == last_idx_s)));
        // Only words answering an outstanding request are written; stray valids drop here
        wr_en_s      = valid && cs_q_r && (count_r != 2'd2);
    end

    // Fetch request: buffered plus in-flight words must stay below the FIFO depth
    always_comb begin
        credit_s = (({1'b0, count_r} + {2'b00, cs_q_r}) < DEPTH_C);
        if ((state_r == ST_RUN) && !eof_seen_r && !(valid && eof && cs_q_r) && credit_s) begin
            cs_s = 1'b1;
        end else begin
            cs_s = 1'b0;
        end
    end

    // MSB-first byte selection from the FIFO head
    always_comb begin
        case (idx_r)
            3'd0:    byte_sel_s = head_word_s[63:56];
            3'd1:    byte_sel_s = head_word_s[55:48];
            3'd2:    byte_sel_s = head_word_s[47:40];
            3'd3:    byte_sel_s = head_word_s[39:32];
            3'd4:    byte_sel_s = head_word_s[31:24];
            3'd5:    byte_sel_s = head_word_s[23:16];
            3'd6:    byte_sel_s = head_word_s[15:8];
            default: byte_sel_s = head_word_s[7:0];
        endcase
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_RUN;
                else       state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (wr_en_s && eof) state_s = ST_DRAIN;
                else                state_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (hs_s && byte_last_s) state_s = ST_DONE;
                else                     state_s = ST_DRAIN;
            end
            ST_DONE: state_s = ST_DONE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, request tracking and byte index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cs_q_r     <= 1'b0;
            eof_seen_r <= 1'b0;
            idx_r      <= 3'd0;
        end else begin
            state_r <= state_s;
            cs_q_r  <= cs_s;
            if (wr_en_s && eof) eof_seen_r <= 1'b1;
            if (pop_s)          idx_r <= 3'd0;
            else if (hs_s)      idx_r <= idx_r + 3'd1;
        end
    end

    // Two-entry word FIFO with eof tag; write and pop may coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0]     <= '0;
            mem_r[1]     <= '0;
            eof_mem_r[0] <= 1'b0;
            eof_mem_r[1] <= 1'b0;
            wr_ptr_r     <= 1'b0;
            rd_ptr_r     <= 1'b0;
            count_r      <= 2'd0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r]     <= data_out;
                eof_mem_r[wr_ptr_r] <= eof;
                wr_ptr_r            <= ~wr_ptr_r;
            end
            if (pop_s) rd_ptr_r <= ~rd_ptr_r;
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Output drive from FIFO head and state registers
    always_comb begin
        cs         = cs_s;
        byte_valid = byte_valid_s;
        byte_last  = byte_last_s;
        done       = (state_r == ST_DONE);
        if (byte_valid_s) begin
            byte_out = byte_sel_s;
        end else begin
            byte_out = 8'd0;
        end
    end

endmodule
